serial_tx_controller: RTL

Transmit-side controller for the team's single-wire serial link: accepts a parallel word under a load/ready handshake, announces the frame with a `valid` start strobe, then shifts the word out LSB-first with an optional even-parity bit. It is the sending end for the existing receive controller and its `RxReg` datapath. That receiver detects `valid`, counts bits with its own counter, compares against the word length, and loads `RxReg`. Bit timing is programmable in clock cycles per bit.

---
 rtl/serial_tx_controller_if.sv | 29 ++
 rtl/serial_tx_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_tx_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_controller_if
// Purpose  : Load/ready handshake and serial-line bundle between a word
//            source (master) and the serial transmit controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface serial_tx_controller_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             busy;
  logic             valid;
  logic             serial_out;
  logic             done;

  modport master (
    output load, data_in,
    input  ready, busy, valid, serial_out, done
  );

  modport slave (
    input  load, data_in,
    output ready, busy, valid, serial_out, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_tx_controller.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_controller
// Purpose  : Accepts a parallel word on load/ready, emits a one-symbol valid
//            start strobe, then shifts the word out LSB-first with an optional
//            even-parity bit. Every symbol lasts BIT_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_controller #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  serial_tx_controller_if.slave  bus
);

  localparam int c_cyc_w = $clog2(BIT_CYCLES + 1);
  localparam int c_bit_w = $clog2(WIDTH + 1);
  localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(BIT_CYCLES - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [c_bit_w-1:0] bitcnt_q;
  logic [c_cyc_w-1:0] cyccnt_q;
  logic               parity_q;
  logic               ready_q;
  logic               busy_q;
  logic               valid_q;
  logic               sout_q;
  logic               done_q;

  // High on the last clock of the symbol currently on the line.
  logic sym_end_w;
  assign sym_end_w = (cyccnt_q == c_cyc_last);

  // Frame sequencer; outputs are loaded alongside the state they describe so
  // that every output is a flop reflecting the current state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      cyccnt_q <= '0;
      parity_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load) begin
            shreg_q  <= bus.data_in;
            bitcnt_q <= '0;
            cyccnt_q <= '0;
            parity_q <= ^bus.data_in;
            state_q  <= ST_START;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            valid_q  <= 1'b1;
            sout_q   <= 1'b0;
          end
        end

        ST_START: begin
          if (sym_end_w) begin
            cyccnt_q <= '0;
            state_q  <= ST_DATA;
            valid_q  <= 1'b0;
            sout_q   <= shreg_q[0];
          end else begin
            cyccnt_q <= cyccnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (sym_end_w) begin
            cyccnt_q <= '0;
            shreg_q  <= shreg_q >> 1;
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == c_bit_last) begin
              if (PARITY_EN != 0) begin
                state_q <= ST_PARITY;
                sout_q  <= parity_q;
              end else begin
                state_q <= ST_DONE;
                sout_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              // Next bit is what becomes bit 0 after this shift.
              sout_q <= shreg_q[1];
            end
          end else begin
            cyccnt_q <= cyccnt_q + 1'b1;
          end
        end

        ST_PARITY: begin
          if (sym_end_w) begin
            cyccnt_q <= '0;
            state_q  <= ST_DONE;
            sout_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cyccnt_q <= cyccnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          sout_q  <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          cyccnt_q <= '0;
          bitcnt_q <= '0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          valid_q  <= 1'b0;
          sout_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.serial_out = sout_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire
